matmul_accel_tiled: RTL and testbench
=====================================

# matmul_accel_tiled

Parametrised, tiled INT8 matrix-vector accelerator on the CPU data-cache port, selected when dcache_addr[31] is set. It computes y = W·x for arbitrary M by iterating over tiles of LANES rows and writes each INT32 result back to memory by DMA, with optional ReLU. It shares the single data-memory port with the CPU and owns the port while busy.

## Interface
- LANES, 4: MAC lanes, which is also the rows per tile (1–8).
- W_DEPTH, 256: 32-bit words of weight storage per lane; the maximum N is 4·W_DEPTH.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mmio_addr  in  32  CPU dcache address; offset is [7:0]
- mmio_wdata  in  32  CPU write data
- mmio_we  in  4  CPU byte enables; any bit set means register write
- mmio_re  in  1  CPU read enable
- mmio_rdata  out  32  register read data, one-cycle latency
- dma_addr  out  32  data-memory byte address, word aligned
- dma_re  out  1  DMA read strobe
- dma_we  out  4  DMA write byte enables (4'hF or 0)
- dma_wdata  out  32  DMA write data
- dma_rdata  in  32  memory read data, valid the cycle after dma_re
- accel_busy  out  1  accelerator owns the dcache port

## Operation
- Register map (offset):
  - 0x00 CTRL/STATUS: write [0]=start, [1]=clear done/err, [2]=relu; read {29'd0, err, done, busy}.
  - 0x04 W_ADDR: weight base address, row-major, N bytes per row.
  - 0x08 X_ADDR: input vector base address.
  - 0x0C M_DIM: number of rows.
  - 0x10 N_DIM: dot-product length.
  - 0x14 Y_ADDR: output base; row r is written at Y_ADDR+4r.
  - 0x18 ROW_CNT: rows written back so far (read only).
  - 0x20+4i RESULT_i, i<LANES: raw accumulator of lane i for the last tile.
  - All other offsets read 0.
- Config writes (0x04–0x14) are accepted only in IDLE/DONE and are ignored while busy. A start write while busy is ignored.
- On start, the block validates the config. If M==0, N==0, N[1:0]!=0, or N/4>W_DEPTH, it goes to DONE with err=1 and done=1, and issues no DMA.
- The relu bit is latched at start.
- State machine:
  - IDLE: waits for start, then goes to LOAD_W.
  - LOAD_W: issues a weight read. LOAD_W_WAIT stores the word into lane[l][w]. After k·nw words it goes to COMP.
  - COMP: issues an x read. COMP_WAIT adds packed_dot(lane[l][j], x_j) into each active lane. After nw words it goes to STORE.
  - STORE: writes one active lane per cycle. Then r0 += LANES; if r0 < M it returns to LOAD_W, otherwise it goes to DONE.
  - DONE: a start write begins a new job. A write to 0x00 with start=0 goes to IDLE and clears done/err.
- Tile variables:
  - nw = N/4.
  - r0 is the first row of the tile.
  - k = min(LANES, M−r0) active lanes.
  - Weight address = W_ADDR + (r0+l)·N + 4w.
- Arithmetic:
  - Bytes are little-endian signed int8; 8×8 products are signed.
  - Four products are summed per word; accumulators are 32-bit two's complement and wrap.
  - Accumulators clear at the start of each tile.
  - Write-back value is acc, or (acc<0 ? 0 : acc) when relu is set. RESULT_i always holds the raw acc.
  - Inactive lanes hold 0 in the final tile.
- ROW_CNT clears on start and increments on each STORE write.

## Timing
- All outputs reset to 0 and state to IDLE; reset is asynchronous and can occur mid-operation.
- dma_re and dma_we drop in the same reset assertion, with no partial write beyond the current cycle.
- Start written in cycle t:
  - accel_busy=1 and dma_re=1 with dma_addr=W_ADDR in cycle t+1 (registered).
  - An error start sets done in t+1, with busy staying 0.
- Reads: dma_re is a one-cycle pulse, and data is sampled the following cycle, giving 2 cycles per word.
- Writes: dma_we=4'hF for one cycle per row, with address and data valid in the same cycle.
- Cycles per tile = 2·k·nw + 2·nw + k.
- done=1 and busy=0 in the cycle after the last STORE write.
- MMIO read: the offset is registered on the cycle mmio_re is high, and mmio_rdata is combinational from the registered offset on the next cycle.
- STATUS read while busy returns busy=1, done=0.

## Test plan
- LANES=4, M=4, N=8, W rows all 0x01, x=0x02 bytes: each y=16, the Y region holds 16 ×4, RESULT0..3=16, and total job cycles = 2·4·2+4+4 = 24.
- M=6, N=4 (two tiles, k=4 then 2): verify 6 writes at Y_ADDR..+20, ROW_CNT=6, RESULT2/3=0 after the final tile, and weight addresses re-based at r0=4.
- Signed extremes, W bytes 0x80 and x bytes 0x80, N=4: acc = 4·16384 = 65536.
- Signed negative, W=0x80, x=0x7F: acc = −65024; with relu=1 memory holds 0 and RESULT0 = 0xFFFF0200.
- Error starts with N=6, N=0, and N=4·W_DEPTH+4: done=err=1 the next cycle, no dma_re ever, and a clear write returns STATUS to 0.
- Assert reset mid-COMP: outputs are 0 immediately, state is IDLE, and a subsequent job produces correct results. A config write while busy leaves the register unchanged.

Source files
------------

// File: rtl/matmul_accel_tiled_if.sv
// CPU register port and shared data-memory port of the tiled INT8 matmul block.
interface matmul_accel_tiled_if;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [3:0]  mmio_we;
    logic        mmio_re;
    logic [31:0] mmio_rdata;
    logic [31:0] dma_addr;
    logic        dma_re;
    logic [3:0]  dma_we;
    logic [31:0] dma_wdata;
    logic [31:0] dma_rdata;
    logic        accel_busy;

    modport master (
        output mmio_addr, mmio_wdata, mmio_we, mmio_re, dma_rdata,
        input  mmio_rdata, dma_addr, dma_re, dma_we, dma_wdata, accel_busy
    );

    modport slave (
        input  mmio_addr, mmio_wdata, mmio_we, mmio_re, dma_rdata,
        output mmio_rdata, dma_addr, dma_re, dma_we, dma_wdata, accel_busy
    );
endinterface

// File: rtl/matmul_accel_tiled.sv
// Tiled INT8 matrix-vector engine: LANES rows per tile, weights buffered per lane,
// x streamed once per tile, INT32 results written back by DMA with optional ReLU.
module matmul_accel_tiled #(
    parameter int LANES   = 4,
    parameter int W_DEPTH = 256
) (
    input  logic clk,
    input  logic reset,
    matmul_accel_tiled_if.slave bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD_W, LOAD_W_WAIT, COMP, COMP_WAIT, STORE, DONE
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   w_addr_q, w_addr_d, x_addr_q, x_addr_d;
    logic [31:0]   m_dim_q, m_dim_d, n_dim_q, n_dim_d;
    logic [31:0]   y_addr_q, y_addr_d, row_cnt_q, row_cnt_d;
    logic [31:0]   r0_q, r0_d, k_q, k_d, nw_q, nw_d;
    logic [31:0]   wptr_q, wptr_d, xptr_q, xptr_d, yptr_q, yptr_d;
    logic [LW-1:0] l_q, l_d;
    logic [AW-1:0] w_q, w_d;
    logic          relu_q, relu_d, done_q, done_d, err_q, err_d;
    logic [7:0]    rd_off_q, rd_off_d;
    logic [31:0]   acc_q [LANES];
    logic [31:0]   acc_d [LANES];
    logic [31:0]   wmem [LANES][W_DEPTH];
    logic          wmem_we;

    logic [7:0]  off;
    logic        sel, wr, ctrl_wr, start, busy, bad, last_w, last_l;
    logic [31:0] r0_next, st_acc;
    logic        unused_ok;

    function automatic logic [31:0] dot4(input logic [31:0] a,
                                         input logic [31:0] b);
        logic signed [15:0] p;
        logic [31:0]        s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            p = 16'($signed(a[8*i +: 8])) * 16'($signed(b[8*i +: 8]));
            s = s + 32'(p);
        end
        return s;
    endfunction

    function automatic logic [31:0] kmin(input logic [31:0] rem);
        return (rem > 32'(LANES)) ? 32'(LANES) : rem;
    endfunction

    assign sel     = bus.mmio_addr[31];
    assign off     = bus.mmio_addr[7:0];
    assign wr      = sel && (|bus.mmio_we);
    assign ctrl_wr = wr && (off == 8'h00);
    assign start   = ctrl_wr && bus.mmio_wdata[0];
    assign busy    = !(state_q == IDLE || state_q == DONE);
    assign bad     = (m_dim_q == '0) || (n_dim_q == '0) ||
                     (n_dim_q[1:0] != 2'b00) ||
                     ((n_dim_q >> 2) > 32'(W_DEPTH));
    assign last_w  = (32'(w_q) == nw_q - 32'd1);
    assign last_l  = (32'(l_q) == k_q - 32'd1);
    assign r0_next = r0_q + 32'(LANES);
    assign st_acc  = acc_q[l_q];
    assign unused_ok = ^{bus.mmio_addr[30:8]};

    always_comb begin
        state_d   = state_q;
        w_addr_d  = w_addr_q;
        x_addr_d  = x_addr_q;
        m_dim_d   = m_dim_q;
        n_dim_d   = n_dim_q;
        y_addr_d  = y_addr_q;
        row_cnt_d = row_cnt_q;
        r0_d      = r0_q;
        k_d       = k_q;
        nw_d      = nw_q;
        wptr_d    = wptr_q;
        xptr_d    = xptr_q;
        yptr_d    = yptr_q;
        l_d       = l_q;
        w_d       = w_q;
        relu_d    = relu_q;
        done_d    = done_q;
        err_d     = err_q;
        rd_off_d  = rd_off_q;
        wmem_we   = 1'b0;
        for (int i = 0; i < LANES; i++) acc_d[i] = acc_q[i];

        if (sel && bus.mmio_re) rd_off_d = off;

        if (wr && !busy) begin
            case (off)
                8'h04:   w_addr_d = bus.mmio_wdata;
                8'h08:   x_addr_d = bus.mmio_wdata;
                8'h0C:   m_dim_d  = bus.mmio_wdata;
                8'h10:   n_dim_d  = bus.mmio_wdata;
                8'h14:   y_addr_d = bus.mmio_wdata;
                default: ;
            endcase
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    row_cnt_d = '0;
                    relu_d    = bus.mmio_wdata[2];
                    if (bad) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LOAD_W;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        r0_d    = '0;
                        k_d     = kmin(m_dim_q);
                        nw_d    = n_dim_q >> 2;
                        wptr_d  = w_addr_q;
                        xptr_d  = x_addr_q;
                        yptr_d  = y_addr_q;
                        l_d     = '0;
                        w_d     = '0;
                        for (int i = 0; i < LANES; i++) acc_d[i] = '0;
                    end
                end else if (ctrl_wr) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            LOAD_W: begin
                wptr_d  = wptr_q + 32'd4;
                state_d = LOAD_W_WAIT;
            end
            LOAD_W_WAIT: begin
                wmem_we = 1'b1;
                state_d = LOAD_W;
                if (last_w) begin
                    w_d = '0;
                    if (last_l) begin
                        l_d     = '0;
                        state_d = COMP;
                    end else begin
                        l_d = l_q + 1'b1;
                    end
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            COMP: begin
                xptr_d  = xptr_q + 32'd4;
                state_d = COMP_WAIT;
            end
            COMP_WAIT: begin
                for (int i = 0; i < LANES; i++) begin
                    if (32'(i) < k_q)
                        acc_d[i] = acc_q[i] + dot4(wmem[i][w_q], bus.dma_rdata);
                end
                if (last_w) begin
                    w_d     = '0;
                    state_d = STORE;
                end else begin
                    w_d     = w_q + 1'b1;
                    state_d = COMP;
                end
            end
            STORE: begin
                yptr_d    = yptr_q + 32'd4;
                row_cnt_d = row_cnt_q + 32'd1;
                if (last_l) begin
                    l_d = '0;
                    // weight rows are contiguous, so wptr just keeps running
                    if (r0_next < m_dim_q) begin
                        state_d = LOAD_W;
                        r0_d    = r0_next;
                        k_d     = kmin(m_dim_q - r0_next);
                        xptr_d  = x_addr_q;
                        for (int i = 0; i < LANES; i++) acc_d[i] = '0;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    l_d = l_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            w_addr_q  <= '0;
            x_addr_q  <= '0;
            m_dim_q   <= '0;
            n_dim_q   <= '0;
            y_addr_q  <= '0;
            row_cnt_q <= '0;
            r0_q      <= '0;
            k_q       <= '0;
            nw_q      <= '0;
            wptr_q    <= '0;
            xptr_q    <= '0;
            yptr_q    <= '0;
            l_q       <= '0;
            w_q       <= '0;
            relu_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_off_q  <= '0;
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            w_addr_q  <= w_addr_d;
            x_addr_q  <= x_addr_d;
            m_dim_q   <= m_dim_d;
            n_dim_q   <= n_dim_d;
            y_addr_q  <= y_addr_d;
            row_cnt_q <= row_cnt_d;
            r0_q      <= r0_d;
            k_q       <= k_d;
            nw_q      <= nw_d;
            wptr_q    <= wptr_d;
            xptr_q    <= xptr_d;
            yptr_q    <= yptr_d;
            l_q       <= l_d;
            w_q       <= w_d;
            relu_q    <= relu_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_off_q  <= rd_off_d;
            for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (wmem_we) wmem[l_q][w_q] <= bus.dma_rdata;
    end

    // DMA strobes decode straight from the state flop so reset kills them at once
    always_comb begin
        bus.dma_re    = (state_q == LOAD_W) || (state_q == COMP);
        bus.dma_we    = (state_q == STORE) ? 4'hF : 4'h0;
        bus.dma_addr  = '0;
        bus.dma_wdata = '0;
        case (state_q)
            LOAD_W: bus.dma_addr = wptr_q;
            COMP:   bus.dma_addr = xptr_q;
            STORE: begin
                bus.dma_addr  = yptr_q;
                bus.dma_wdata = (relu_q && st_acc[31]) ? '0 : st_acc;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.mmio_rdata = '0;
        case (rd_off_q)
            8'h00: bus.mmio_rdata = {29'd0, err_q, done_q, busy};
            8'h04: bus.mmio_rdata = w_addr_q;
            8'h08: bus.mmio_rdata = x_addr_q;
            8'h0C: bus.mmio_rdata = m_dim_q;
            8'h10: bus.mmio_rdata = n_dim_q;
            8'h14: bus.mmio_rdata = y_addr_q;
            8'h18: bus.mmio_rdata = row_cnt_q;
            default: begin
                for (int i = 0; i < LANES; i++) begin
                    if (rd_off_q == 8'(32 + 4 * i)) bus.mmio_rdata = acc_q[i];
                end
            end
        endcase
    end

    assign bus.accel_busy = busy;
endmodule

// File: tb/tb_matmul_accel_tiled.sv
// Directed plus randomized bench for matmul_accel_tiled against a plain
// arithmetic model of y = W*x with a word-addressed memory behind the DMA port.
module tb_matmul_accel_tiled;
    localparam int L  = 4;
    localparam int WD = 256;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] WB   = 32'h0000_1000;
    localparam logic [31:0] XB   = 32'h0000_3000;
    localparam logic [31:0] YB   = 32'h0000_3800;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    matmul_accel_tiled_if bus ();

    matmul_accel_tiled #(.LANES(L), .W_DEPTH(WD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [4096];
    logic [31:0] ra_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int re_cnt = 0;
    int vecs = 0;
    int errs = 0;
    byte wb [1024];
    byte xb [64];
    int  y_raw [64];

    always @(posedge clk) begin
        if (bus.dma_re) begin
            bus.dma_rdata <= mem[bus.dma_addr[13:2]];
            ra_q.push_back(bus.dma_addr);
            re_cnt++;
        end
        if (bus.dma_we == 4'hF) begin
            wa_q.push_back(bus.dma_addr);
            wd_q.push_back(bus.dma_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mmio_write(input logic [7:0] off, input logic [31:0] d);
        @(negedge clk);
        bus.mmio_addr  = BASE | 32'(off);
        bus.mmio_wdata = d;
        bus.mmio_we    = 4'hF;
        bus.mmio_re    = 1'b1;
        @(negedge clk);
        bus.mmio_we = 4'h0;
        bus.mmio_re = 1'b0;
    endtask

    task automatic mmio_read(input logic [7:0] off, output logic [31:0] d);
        @(negedge clk);
        bus.mmio_addr = BASE | 32'(off);
        bus.mmio_re   = 1'b1;
        @(negedge clk);
        bus.mmio_re = 1'b0;
        d = bus.mmio_rdata;
    endtask

    task automatic set_byte(input logic [31:0] a, input byte b);
        mem[a[13:2]][8*a[1:0] +: 8] = b;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus.accel_busy && cyc < 20000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_job(input int m, input int n, input bit relu,
                           input string tag);
        int nw, cyc, exp_cyc, rb, wb0, nbad, r0l, k, s;
        logic [31:0] d, yv;
        logic [31:0] exp_rd[$];
        for (int r = 0; r < m; r++)
            for (int j = 0; j < n; j++)
                set_byte(WB + 32'(r * n + j), wb[r * n + j]);
        for (int j = 0; j < n; j++) set_byte(XB + 32'(j), xb[j]);
        for (int r = 0; r < m; r++) begin
            s = 0;
            for (int j = 0; j < n; j++) s += int'(wb[r * n + j]) * int'(xb[j]);
            y_raw[r] = s;
        end
        nw = n / 4;
        exp_cyc = 0;
        for (int r0 = 0; r0 < m; r0 += L) begin
            k = (m - r0 < L) ? m - r0 : L;
            exp_cyc += 2 * k * nw + 2 * nw + k;
            for (int l = 0; l < k; l++)
                for (int w = 0; w < nw; w++)
                    exp_rd.push_back(WB + 32'((r0 + l) * n + 4 * w));
            for (int j = 0; j < nw; j++) exp_rd.push_back(XB + 32'(4 * j));
        end
        mmio_write(8'h04, WB);
        mmio_write(8'h08, XB);
        mmio_write(8'h0C, 32'(m));
        mmio_write(8'h10, 32'(n));
        mmio_write(8'h14, YB);
        rb  = ra_q.size();
        wb0 = wa_q.size();
        mmio_write(8'h00, {29'd0, relu, 2'b01});
        chk({tag, "/busy1"}, 32'(bus.accel_busy), 32'd1);
        chk({tag, "/re1"}, 32'(bus.dma_re), 32'd1);
        chk({tag, "/addr1"}, bus.dma_addr, WB);
        wait_idle(cyc);
        chk({tag, "/cycles"}, 32'(cyc), 32'(exp_cyc));
        mmio_read(8'h00, d);
        chk({tag, "/status"}, d, 32'h2);
        nbad = 0;
        if (ra_q.size() - rb != exp_rd.size()) nbad++;
        else
            for (int i = 0; i < exp_rd.size(); i++)
                if (ra_q[rb + i] !== exp_rd[i]) nbad++;
        chk({tag, "/rdaddr_bad"}, 32'(nbad), 32'd0);
        chk({tag, "/nwrites"}, 32'(wa_q.size() - wb0), 32'(m));
        nbad = 0;
        for (int r = 0; r < m && wb0 + r < wa_q.size(); r++) begin
            yv = (relu && y_raw[r] < 0) ? 32'd0 : 32'(y_raw[r]);
            if (wa_q[wb0 + r] !== YB + 32'(4 * r)) nbad++;
            if (wd_q[wb0 + r] !== yv) nbad++;
        end
        chk({tag, "/wr_bad"}, 32'(nbad), 32'd0);
        mmio_read(8'h18, d);
        chk({tag, "/row_cnt"}, d, 32'(m));
        r0l = ((m - 1) / L) * L;
        for (int i = 0; i < L; i++) begin
            mmio_read(8'(32 + 4 * i), d);
            chk($sformatf("%s/result%0d", tag, i), d,
                (i < m - r0l) ? 32'(y_raw[r0l + i]) : 32'd0);
        end
        mmio_write(8'h00, 32'h2);
        mmio_read(8'h00, d);
        chk({tag, "/clr"}, d, 32'h0);
    endtask

    initial begin
        logic [31:0] d;
        int rc, cyc, m, n;
        int em [4] = '{4, 4, 4, 0};
        int en [4] = '{6, 0, 4 * WD + 4, 4};
        bus.mmio_addr  = '0;
        bus.mmio_wdata = '0;
        bus.mmio_we    = '0;
        bus.mmio_re    = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst/re", 32'(bus.dma_re), 32'd0);
        chk("rst/we", 32'(bus.dma_we), 32'd0);
        chk("rst/busy", 32'(bus.accel_busy), 32'd0);
        chk("rst/addr", bus.dma_addr, 32'd0);
        chk("rst/rdata", bus.mmio_rdata, 32'd0);
        reset = 1'b0;
        mmio_read(8'h00, d);
        chk("rst/status", d, 32'h0);

        for (int i = 0; i < 32; i++) wb[i] = 8'sh01;
        for (int j = 0; j < 8; j++) xb[j] = 8'sh02;
        run_job(4, 8, 1'b0, "ones");

        for (int i = 0; i < 24; i++) wb[i] = byte'($urandom);
        for (int j = 0; j < 4; j++) xb[j] = byte'($urandom);
        run_job(6, 4, 1'b0, "two_tiles");

        for (int i = 0; i < 4; i++) wb[i] = 8'sh80;
        for (int j = 0; j < 4; j++) xb[j] = 8'sh80;
        run_job(1, 4, 1'b0, "sgn_max");

        for (int j = 0; j < 4; j++) xb[j] = 8'sh7F;
        run_job(1, 4, 1'b1, "sgn_neg_relu");

        for (int e = 0; e < 4; e++) begin
            mmio_write(8'h0C, 32'(em[e]));
            mmio_write(8'h10, 32'(en[e]));
            rc = re_cnt;
            mmio_write(8'h00, 32'h1);
            chk($sformatf("err%0d/status", e), bus.mmio_rdata, 32'h6);
            chk($sformatf("err%0d/busy", e), 32'(bus.accel_busy), 32'd0);
            repeat (4) @(negedge clk);
            chk($sformatf("err%0d/no_dma", e), 32'(re_cnt - rc), 32'd0);
            mmio_write(8'h00, 32'h2);
            mmio_read(8'h00, d);
            chk($sformatf("err%0d/clr", e), d, 32'h0);
        end

        for (int i = 0; i < 32; i++) wb[i] = 8'sh01;
        for (int j = 0; j < 8; j++) xb[j] = 8'sh02;
        run_job(4, 8, 1'b0, "prep");
        mmio_write(8'h00, 32'h1);
        mmio_write(8'h04, 32'h0000_2000);
        mmio_read(8'h04, d);
        chk("busy_cfg/w_addr", d, WB);
        wait_idle(cyc);
        chk("busy_cfg/idle", 32'(bus.accel_busy), 32'd0);
        mmio_write(8'h00, 32'h2);

        for (int i = 0; i < 128; i++) wb[i] = byte'($urandom);
        for (int j = 0; j < 32; j++) xb[j] = byte'($urandom);
        mmio_write(8'h0C, 32'd4);
        mmio_write(8'h10, 32'd32);
        mmio_write(8'h00, 32'h1);
        repeat (66) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst/re", 32'(bus.dma_re), 32'd0);
        chk("midrst/we", 32'(bus.dma_we), 32'd0);
        chk("midrst/addr", bus.dma_addr, 32'd0);
        chk("midrst/busy", 32'(bus.accel_busy), 32'd0);
        chk("midrst/rdata", bus.mmio_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mmio_read(8'h00, d);
        chk("midrst/status", d, 32'h0);
        run_job(4, 32, 1'b1, "post_rst");

        for (int t = 0; t < 6; t++) begin
            m = $urandom_range(1, 9);
            n = 4 * $urandom_range(1, 8);
            for (int i = 0; i < m * n; i++) wb[i] = byte'($urandom);
            for (int j = 0; j < n; j++) xb[j] = byte'($urandom);
            run_job(m, n, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
